// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } sched_st_t;

    localparam int TOUT_CYC = 4;

    // Bits needed to hold a counter that counts up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set bit of valid, starting one past last and wrapping.
module rr_pick #(
    parameter  int r = 4,
    localparam int w = $clog2(r)
) (
    input  logic [r-1:0] valid,
    input  logic [w-1:0] last,
    output logic         found,
    output logic [w-1:0] pick
);

    logic [w-1:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = last;
        idx   = last;
        // last itself is probed at i == r, so a lone requester can win again
        for (int i = 1; i <= r; i++) begin
            idx = w'((int'(last) + i) % r);
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin burst scheduler sharing one UART transmitter among r requesters,
// with a sticky timeout flag when busy fails to rise after a start.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter  int n     = 8,
    parameter  int r     = 4,
    parameter  int burst = 4,
    localparam int w     = $clog2(r)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [r-1:0] req_valid_i,
    input  logic [n-1:0] req_data_i [0:r-1],
    output logic [r-1:0] req_ready_o,
    output logic [r-1:0] grant_o,
    output logic [w-1:0] owner_o,
    output logic [n-1:0] tx_data_o,
    output logic         tx_start_o,
    input  logic         tx_busy_i,
    output logic         active_o,
    output logic         tout_o
);

    localparam int BCNT_W = cnt_width(burst);
    localparam int TOUT_W = cnt_width(TOUT_CYC);

    sched_st_t   state_q, state_d;
    logic [w-1:0] last_q, last_d;
    logic [w-1:0] owner_d;
    logic [r-1:0] grant_d, ready_d;
    logic [n-1:0] data_d;
    logic         start_d, tout_d, end_byte;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [TOUT_W-1:0] tcnt_q, tcnt_d;
    logic         pick_found;
    logic [w-1:0] pick_idx;

    function automatic logic [r-1:0] onehot(input logic [w-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    rr_pick #(.r(r)) u_pick (
        .valid (req_valid_i),
        .last  (last_q),
        .found (pick_found),
        .pick  (pick_idx)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_o;
        grant_d  = grant_o;
        data_d   = tx_data_o;
        start_d  = 1'b0;
        ready_d  = '0;
        bcnt_d   = bcnt_q;
        tcnt_d   = tcnt_q;
        tout_d   = tout_o;
        end_byte = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!tx_busy_i && pick_found) begin
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    grant_d = onehot(pick_idx);
                    data_d  = req_data_i[pick_idx];
                    bcnt_d  = BCNT_W'(1);
                    start_d = 1'b1;
                    ready_d = onehot(pick_idx);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tcnt_d  = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tcnt_d = tcnt_q + TOUT_W'(1);
                    if (tcnt_q == TOUT_W'(TOUT_CYC - 1)) begin
                        tout_d   = 1'b1;
                        end_byte = 1'b1;
                    end
                end
            end
            ST_WAIT_DONE: begin
                end_byte = !tx_busy_i;
            end
            default: state_d = ST_IDLE;
        endcase

        // Continue the burst only while the owner still has data and quota left.
        if (end_byte) begin
            if (req_valid_i[owner_o] && (bcnt_q < BCNT_W'(burst))) begin
                data_d  = req_data_i[owner_o];
                bcnt_d  = bcnt_q + BCNT_W'(1);
                start_d = 1'b1;
                ready_d = onehot(owner_o);
                state_d = ST_SEND;
            end else begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            last_q      <= w'(r - 1);
            owner_o     <= '0;
            grant_o     <= '0;
            tx_data_o   <= '0;
            tx_start_o  <= 1'b0;
            req_ready_o <= '0;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            tout_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_o     <= owner_d;
            grant_o     <= grant_d;
            tx_data_o   <= data_d;
            tx_start_o  <= start_d;
            req_ready_o <= ready_d;
            bcnt_q      <= bcnt_d;
            tcnt_q      <= tcnt_d;
            tout_o      <= tout_d;
        end
    end

    assign active_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench: requester FIFOs and a transmitter model around uart_tx_sched,
// with the expected byte order derived from the round-robin burst rules.
module tb_uart_tx_sched;

    localparam int N     = 8;
    localparam int R     = 4;
    localparam int BURST = 4;
    localparam int QCAP  = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [R-1:0]   req_valid = '0;
    logic [N-1:0]   req_data [0:R-1];
    logic [R-1:0]   req_ready;
    logic [R-1:0]   grant;
    logic [1:0]     owner;
    logic [N-1:0]   tx_data;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic           active;
    logic           tout;

    // Requester FIFOs
    logic [N-1:0] qmem [R][QCAP];
    int           qhead [R];
    int           qtail [R];

    // Expected transmissions, in order
    int           exp_idx[$];
    logic [N-1:0] exp_data[$];
    int           exp_owner;
    int           model_last;

    // Transmitter model
    int  tx_rem;
    int  frame_len;
    bit  tx_dead;
    bit  busy_model;
    bit  busy_ext;

    int  n_checks;
    int  n_errors;
    int  cyc;
    int  starts;
    int  ready_cnt [R];

    uart_tx_sched #(.n(N), .r(R), .burst(BURST)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .owner_o     (owner),
        .tx_data_o   (tx_data),
        .tx_start_o  (tx_start),
        .tx_busy_i   (tx_busy),
        .active_o    (active),
        .tout_o      (tout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [N-1:0] b);
        if (qhead[k] == qtail[k]) begin
            qhead[k] = 0;
            qtail[k] = 0;
        end
        qmem[k][qtail[k]] = b;
        qtail[k]++;
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < R; k++) begin
            req_valid[k] = (qhead[k] != qtail[k]);
            req_data[k]  = req_valid[k] ? qmem[k][qhead[k]] : '0;
        end
        tx_busy = busy_model | busy_ext;
    endtask

    // Order of bytes on the wire: each grant goes to the next non-empty FIFO after
    // the previous owner, and takes at most BURST bytes from it.
    task automatic build_expected();
        int  pos [R];
        int  p;
        int  k;
        int  take;
        bit  more;
        for (int i = 0; i < R; i++) pos[i] = qhead[i];
        p    = model_last;
        more = 1'b1;
        while (more) begin
            more = 1'b0;
            k    = -1;
            for (int i = 1; i <= R; i++) begin
                if (k < 0 && pos[(p + i) % R] < qtail[(p + i) % R]) k = (p + i) % R;
            end
            if (k >= 0) begin
                more = 1'b1;
                take = qtail[k] - pos[k];
                if (take > BURST) take = BURST;
                for (int j = 0; j < take; j++) begin
                    exp_idx.push_back(k);
                    exp_data.push_back(qmem[k][pos[k]]);
                    pos[k]++;
                end
                p = k;
            end
        end
        model_last = p;
    endtask

    task automatic step();
        int k;
        logic [N-1:0] d;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_start) begin
            starts++;
            if (exp_idx.size() == 0) begin
                check("unexpected_start", 32'(owner), 32'hFFFF_FFFF);
            end else begin
                k = exp_idx.pop_front();
                d = exp_data.pop_front();
                check("start_owner", 32'(owner), 32'(k));
                check("start_grant", 32'(grant), 32'(1 << k));
                check("start_ready", 32'(req_ready), 32'(1 << k));
                check("start_data", 32'(tx_data), 32'(d));
                exp_owner = k;
            end
        end
        check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        check("ready_with_start", 32'(req_ready != '0), 32'(tx_start));
        if (active) check("grant_owner", 32'(grant), 32'(1 << exp_owner));
        else        check("grant_idle", 32'(grant), 32'd0);
        for (int i = 0; i < R; i++) begin
            if (req_ready[i]) begin
                ready_cnt[i]++;
                if (qhead[i] != qtail[i]) qhead[i]++;
            end
        end
        if (tx_rem > 0) begin
            busy_model = 1'b1;
            tx_rem--;
        end else begin
            busy_model = 1'b0;
        end
        if (tx_start && !tx_dead) tx_rem = frame_len;
        drive_reqs();
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!tx_start && n < budget);
        check("start_seen", 32'(tx_start), 32'd1);
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while ((exp_idx.size() != 0 || active || tx_busy) && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
        repeat (3) step();
    endtask

    task automatic check_outputs_zero();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_tout", 32'(tout), 32'd0);
    endtask

    // Asserts reset immediately (mid-cycle), holds it across two edges, then releases.
    task automatic apply_reset();
        rst        = 1'b1;
        tx_rem     = 0;
        busy_model = 1'b0;
        exp_idx.delete();
        exp_data.delete();
        model_last = R - 1;
        exp_owner  = 0;
        starts     = 0;
        for (int k = 0; k < R; k++) ready_cnt[k] = 0;
        drive_reqs();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs_zero();
        rst = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        tx_dead   = 1'b0;
        busy_ext  = 1'b0;
        frame_len = 10;
        for (int k = 0; k < R; k++) begin
            qhead[k]    = 0;
            qtail[k]    = 0;
            req_data[k] = '0;
        end

        #1 rst = 1'b1;
        #1 check_outputs_zero();
        apply_reset();

        // Single requester 2, two bytes
        push(2, 8'hA5);
        push(2, 8'h3C);
        build_expected();
        drive_reqs();
        run_drain(500);
        check("t2_starts", 32'(starts), 32'd2);
        check("t2_ready_cnt", 32'(ready_cnt[2]), 32'd2);

        // All four requesters saturated: bursts of 4 rotate 0,1,2,3,0,...
        apply_reset();
        frame_len = 3;
        for (int k = 0; k < R; k++)
            for (int j = 0; j < 8; j++) push(k, 8'((k << 4) | j));
        build_expected();
        drive_reqs();
        run_drain(2000);
        check("t3_starts", 32'(starts), 32'd32);

        // Requester 1 empties after 2 bytes while 3 waits
        apply_reset();
        push(1, 8'h11);
        push(1, 8'h12);
        push(3, 8'h31);
        push(3, 8'h32);
        build_expected();
        drive_reqs();
        run_drain(1000);
        check("t4_ready1", 32'(ready_cnt[1]), 32'd2);
        check("t4_ready3", 32'(ready_cnt[3]), 32'd2);

        // Dead transmitter: timeout five cycles after the start pulse
        apply_reset();
        tx_dead = 1'b1;
        push(0, 8'hC1);
        push(0, 8'hC2);
        build_expected();
        drive_reqs();
        wait_start(20);
        repeat (4) begin
            step();
            check("tout_early", 32'(tout), 32'd0);
        end
        step();
        check("tout_set", 32'(tout), 32'd1);
        run_drain(200);
        check("tout_sticky", 32'(tout), 32'd1);
        check("t5_starts", 32'(starts), 32'd2);
        tx_dead = 1'b0;
        apply_reset();
        check("tout_cleared", 32'(tout), 32'd0);

        // Busy held externally: nothing starts until two cycles after the last busy-high cycle
        busy_ext = 1'b1;
        push(0, 8'h5A);
        build_expected();
        drive_reqs();
        repeat (6) begin
            step();
            check("busy_hold_start", 32'(tx_start), 32'd0);
        end
        begin
            int last_high;
            last_high = cyc;
            busy_ext  = 1'b0;
            wait_start(20);
            check("busy_fall_start", 32'(cyc - last_high), 32'd2);
        end
        run_drain(200);

        // Reset while waiting for the frame to finish
        apply_reset();
        frame_len = 8;
        push(1, 8'h71);
        push(1, 8'h72);
        push(1, 8'h73);
        push(2, 8'h81);
        push(2, 8'h82);
        build_expected();
        drive_reqs();
        wait_start(20);
        repeat (3) step();
        check("pre_reset_active", 32'(active), 32'd1);
        #2 rst = 1'b1;
        #1 check_outputs_zero();
        apply_reset();
        build_expected();
        drive_reqs();
        wait_start(20);
        check("post_reset_owner", 32'(owner), 32'd1);
        run_drain(1000);

        // Randomized rounds, rotation state carried across rounds
        for (int round = 0; round < 10; round++) begin
            frame_len = $urandom_range(1, 12);
            for (int k = 0; k < R; k++) begin
                int len;
                len = $urandom_range(0, 6);
                for (int j = 0; j < len; j++) push(k, 8'($urandom));
            end
            build_expected();
            drive_reqs();
            run_drain(3000);
            check("rand_leftover", 32'(exp_idx.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter between `r` byte-stream requesters. It sits between the requester FIFOs' read side and the UART TX start/busy handshake. It grants one requester at a time for a burst of up to `burst` bytes, sequences each byte through the transmitter, then rotates ownership. Transmitter loss is detected by a busy-rise timeout.

## Interface
- `n`, 8, data width in bits.
- `r`, 4, number of requesters (≥2).
- `burst`, 4, maximum bytes per grant before forced rotation (≥1).
- `w`, `$clog2(r)`, owner index width (derived, not overridden).

- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  r  requester k has a byte; held until its ready pulse.
- `req_data_i`  in  n × [0:r-1]  byte per requester, stable while valid.
- `req_ready_o`  out  r  one-cycle pulse: byte of requester k consumed.
- `grant_o`  out  r  one-hot current owner; all-zero when idle.
- `owner_o`  out  w  index of current/last owner.
- `tx_data_o`  out  n  byte to transmitter, registered.
- `tx_start_o`  out  1  one-cycle start pulse to transmitter.
- `tx_busy_i`  in  1  transmitter frame in progress.
- `active_o`  out  1  high in any state except IDLE.
- `tout_o`  out  1  sticky: busy failed to rise after a start.

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: when `tx_busy_i`=0 and any `req_valid_i` is set, pick the first valid index searching from (last owner + 1) mod r, wrapping. Register owner, grant, `tx_data_o` ← that requester's data, burst count ← 1, then go to SEND. While `tx_busy_i`=1, stay in IDLE.
- SEND: lasts 1 cycle. `tx_start_o`=1 and `req_ready_o[owner]`=1 are both registered pulses. Go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY: `tx_busy_i`=1 → WAIT_DONE. Otherwise increment the counter. When the counter reaches TOUT_CYC (4), set `tout_o` and take the end-of-byte decision below.
- WAIT_DONE: on `tx_busy_i`=0, take the end-of-byte decision:
  - `req_valid_i[owner]`=1 and count < `burst`: latch the next byte, count+1, go to SEND.
  - Otherwise: clear grant and go to IDLE. The last owner is kept for rotation.
- Rotation after reset starts at requester 0 (last owner resets to r-1).
- A requester dropping valid mid-burst ends its grant at the next decision point. No byte is consumed without a ready pulse.
- `tout_o` is cleared only by reset.

## Timing
- Reset values: `req_ready_o`=0, `grant_o`=0, `owner_o`=0, `tx_data_o`=0, `tx_start_o`=0, `active_o`=0, `tout_o`=0. Internal last-owner resets to r-1. State resets to IDLE.
- Reset asserted mid-operation: state returns to IDLE and outputs return to reset values immediately. Any frame already started in the transmitter is not tracked.
- Valid seen in IDLE at cycle t → `tx_start_o`, `req_ready_o[k]` and `grant_o[k]` all high at t+1. `tx_data_o` is valid from t+1.
- Next burst byte: busy falls at cycle d → start at d+1.
- End of grant: busy falls at d → IDLE at d+1 → next owner's start at d+2 at the earliest.
- Simultaneous valids: rotation order decides. The owner never re-wins directly while another requester is valid.
- Only one requester is granted at a time. `req_ready_o` is at most one-hot.

## Structure
- Package `uart_sched_pkg`: state enum `sched_st_t`, constant `TOUT_CYC`=4, and a width helper for the timeout counter.
- Sub-module `rr_pick`: combinational round-robin pointer search, `r`-wide valid vector plus last-owner index in, found flag plus index out.
- Top `uart_tx_sched`: FSM, registers and counters.

## Test plan
- Single requester 2, bytes 0xA5 then 0x3C; model busy high for 10 cycles after start → two starts. `tx_data_o` is 0xA5 then 0x3C, two ready pulses on bit 2, `grant_o`=0b0100 throughout, then returns to 0.
- All four requesters continuously valid, `burst`=4 → 4 bytes from requester 0, then 4 from 1, then 4 from 2, then 4 from 3, then back to 0. No cycle has more than one ready bit set.
- Requester 1 drops valid after 2 of 4 bytes while requester 3 is valid → grant moves to 3 after byte 2. Ready count for requester 1 = 2.
- Transmitter never raises busy → `tout_o`=1 exactly 5 cycles after the start pulse. Scheduler continues with the next byte and does not hang.
- `tx_busy_i` held high externally with requester 0 valid → no start and no grant until busy falls. Start follows at fall+2.
- Assert `rst_i` during WAIT_DONE → all outputs 0 without waiting for a clock edge. After release, the first grant goes to the lowest valid index.
